vp_last_value_table: RTL and testbench
======================================

// Module: vp_last_value_table
// PURPOSE
//  Last-value load predictor table, directly upstream of value_prediction; replaces its fixed all-zeros guess.
//  Direct-mapped, PC-indexed, tagged; each entry holds last loaded value + saturating confidence counter.
//  Lookup at load issue gives predicted value + confidence; trained with the real D-cache value at resolution.
//  Consumer speculates only when pred_confident=1.
// PARAMETERS
//  INDEX_WIDTH  6  log2(entries); 64 entries
//  TAG_WIDTH    8  partial PC tag bits per entry
//  CONF_BITS    2  confidence counter width
//  CONF_THRESH  2  min counter value for pred_confident=1; must be <= 2**CONF_BITS-1
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            async active-low reset
//  lookup_en       in   1            request prediction for lookup_pc
//  lookup_pc       in   `ADDR_WIDTH  load instruction PC
//  pred_valid      out  1            registered response strobe for the lookup of the previous cycle
//  pred_hit        out  1            tag matched a valid entry
//  pred_confident  out  1            hit and counter >= CONF_THRESH
//  pred_value      out  `DATA_WIDTH  predicted value; 0 when not hit
//  pred_pc         out  `ADDR_WIDTH  lookup_pc echoed with the response
//  train_en        in   1            resolved load result present (one pulse per load)
//  train_pc        in   `ADDR_WIDTH  PC of resolved load
//  train_value     in   `DATA_WIDTH  actual loaded data
//  flush           in   1            invalidate every entry
//  stat_correct    out  16           confident predictions later confirmed by training
//  stat_wrong      out  16           confident predictions later contradicted by training
// BEHAVIOUR
//  Reset: all valid bits 0, counters 0; every output 0. Value/tag arrays need no reset.
//  Address split: idx = pc[INDEX_WIDTH+1:2]; tag = pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2].
//  Lookup latency 1 cycle: lookup_en at cycle N gives pred_valid=1 at N+1 with pred_* from array state at N.
//  Lookup is pipelined: one per cycle. pred_valid=0 and other pred_* hold their last values when lookup_en=0.
//  Train takes effect at the clock edge, one of three cases:
//   hit, value equal: counter+1, saturating at 2**CONF_BITS-1.
//   hit, value differs: value <= train_value, counter <= 0.
//   miss (invalid or tag mismatch): allocate: valid=1, tag, value, counter <= 0.
//  Stats: counted only on a train hit whose pre-update counter >= CONF_THRESH.
//   equal value -> stat_correct+1; different value -> stat_wrong+1.
//   Both counters saturate at 16'hFFFF and never wrap.
//  Same-cycle lookup and train to the same idx: read-before-write; the lookup sees old contents.
//  flush: clears all valid bits at the edge, wins over same-cycle train (no allocate).
//   A same-cycle lookup sees pre-flush state. Counters and stats are not cleared by flush.
//  Async reset mid-lookup: the pending response is dropped (pred_valid=0 after reset).
// TESTING
//  Reset, lookup 0x0040_0010 -> N+1: pred_valid=1, pred_hit=0, pred_confident=0, pred_value=0.
//  Train 0x0040_0010 with 0xDEAD_BEEF x3, then lookup -> hit=1, value=0xDEAD_BEEF, confident=1
//   (counter=2), stats unchanged.
//  Continue: train 0xDEAD_BEEF once more (stat_correct=1), then train 0x1234_5678 ->
//   stat_wrong=1, next lookup value=0x1234_5678, confident=0.
//  Alias: train PC 0x0040_0010, then train 0x0040_0110 (same idx, diff tag) ->
//   lookup 0x0040_0010 gives hit=0.
//  Same-cycle lookup+train on one idx -> response shows old value; next-cycle lookup shows new.
//  flush with train same cycle -> all subsequent lookups miss; 70000 confident-correct trains ->
//   stat_correct=16'hFFFF.

Source files
------------

// File: rtl/vp_last_value_table.sv
// Last-value load predictor: direct-mapped, PC-indexed, tagged table of last loaded
// value plus saturating confidence, with one-cycle lookup and train-at-resolution.
module vp_last_value_table #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_en,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_confident,
  output logic [DATA_WIDTH-1:0] pred_value,
  output logic [ADDR_WIDTH-1:0] pred_pc,
  input  logic                  train_en,
  input  logic [ADDR_WIDTH-1:0] train_pc,
  input  logic [DATA_WIDTH-1:0] train_value,
  input  logic                  flush,
  output logic [15:0]           stat_correct,
  output logic [15:0]           stat_wrong
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_LSB = INDEX_WIDTH + 2;
  localparam int TAG_MSB = TAG_LSB + TAG_WIDTH - 1;
  localparam logic [CONF_BITS-1:0] CONF_MAX = {CONF_BITS{1'b1}};
  localparam logic [CONF_BITS-1:0] CONF_TH  = CONF_BITS'(CONF_THRESH);

  logic [ENTRIES-1:0]                valid_q;
  logic [ENTRIES-1:0][CONF_BITS-1:0] conf_q;
  logic [TAG_WIDTH-1:0]              tag_q   [ENTRIES];
  logic [DATA_WIDTH-1:0]             value_q [ENTRIES];

  logic [15:0] stat_correct_q, stat_correct_d;
  logic [15:0] stat_wrong_q, stat_wrong_d;

  logic                  pred_valid_q, pred_hit_q, pred_confident_q;
  logic [DATA_WIDTH-1:0] pred_value_q;
  logic [ADDR_WIDTH-1:0] pred_pc_q;

  logic [INDEX_WIDTH-1:0] lk_idx_s, tr_idx_s;
  logic [TAG_WIDTH-1:0]   lk_tag_s, tr_tag_s;
  logic                   lk_hit_s, tr_hit_s, tr_eq_s, tr_conf_s, tr_act_s, wr_s;
  logic                   unused_pc_s;

  assign lk_idx_s  = lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag_s  = lookup_pc[TAG_MSB:TAG_LSB];
  assign tr_idx_s  = train_pc[INDEX_WIDTH+1:2];
  assign tr_tag_s  = train_pc[TAG_MSB:TAG_LSB];
  assign lk_hit_s  = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
  assign tr_hit_s  = valid_q[tr_idx_s] && (tag_q[tr_idx_s] == tr_tag_s);
  assign tr_eq_s   = (value_q[tr_idx_s] == train_value);
  assign tr_conf_s = (conf_q[tr_idx_s] >= CONF_TH);
  // Flush suppresses the whole training update, including allocation and stats.
  assign tr_act_s  = train_en && !flush;
  assign wr_s      = tr_act_s && !(tr_hit_s && tr_eq_s);
  assign unused_pc_s = ^{lookup_pc[1:0], lookup_pc[ADDR_WIDTH-1:TAG_MSB+1],
                         train_pc[1:0], train_pc[ADDR_WIDTH-1:TAG_MSB+1]};

  // Saturating accuracy statistics for confident predictions.
  always_comb begin
    stat_correct_d = stat_correct_q;
    stat_wrong_d   = stat_wrong_q;
    if (tr_act_s && tr_hit_s && tr_conf_s) begin
      if (tr_eq_s) begin
        stat_correct_d = (stat_correct_q == 16'hFFFF) ? stat_correct_q : stat_correct_q + 16'd1;
      end else begin
        stat_wrong_d = (stat_wrong_q == 16'hFFFF) ? stat_wrong_q : stat_wrong_q + 16'd1;
      end
    end else begin
      stat_correct_d = stat_correct_q;
    end
  end

  // Valid bits, confidence counters and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      conf_q         <= '0;
      stat_correct_q <= 16'd0;
      stat_wrong_q   <= 16'd0;
    end else begin
      stat_correct_q <= stat_correct_d;
      stat_wrong_q   <= stat_wrong_d;
      if (flush) begin
        valid_q <= '0;
      end else if (train_en) begin
        if (tr_hit_s && tr_eq_s) begin
          conf_q[tr_idx_s] <= (conf_q[tr_idx_s] == CONF_MAX) ? CONF_MAX
                                                             : conf_q[tr_idx_s] + CONF_BITS'(1);
        end else begin
          conf_q[tr_idx_s]  <= '0;
          valid_q[tr_idx_s] <= 1'b1;
        end
      end
    end
  end

  // Tag and value storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      tag_q[tr_idx_s]   <= tr_tag_s;
      value_q[tr_idx_s] <= train_value;
    end
  end

  // Registered lookup response; reads pre-edge contents (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q     <= 1'b0;
      pred_hit_q       <= 1'b0;
      pred_confident_q <= 1'b0;
      pred_value_q     <= '0;
      pred_pc_q        <= '0;
    end else begin
      pred_valid_q <= lookup_en;
      if (lookup_en) begin
        pred_hit_q       <= lk_hit_s;
        pred_confident_q <= lk_hit_s && (conf_q[lk_idx_s] >= CONF_TH);
        pred_value_q     <= lk_hit_s ? value_q[lk_idx_s] : '0;
        pred_pc_q        <= lookup_pc;
      end
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_hit       = pred_hit_q;
  assign pred_confident = pred_confident_q;
  assign pred_value     = pred_value_q;
  assign pred_pc        = pred_pc_q;
  assign stat_correct   = stat_correct_q;
  assign stat_wrong     = stat_wrong_q;

endmodule

// File: tb/tb_vp_last_value_table.sv
// Bench for vp_last_value_table: directed scenarios plus random traffic, all checked
// every cycle against a per-entry behavioural model of the predictor table.
module tb_vp_last_value_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_en, train_en, flush;
  logic [31:0] lookup_pc, train_pc, train_value;
  logic        pred_valid, pred_hit, pred_confident;
  logic [31:0] pred_value, pred_pc;
  logic [15:0] stat_correct, stat_wrong;

  vp_last_value_table dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_confident(pred_confident),
    .pred_value(pred_value), .pred_pc(pred_pc),
    .train_en(train_en), .train_pc(train_pc), .train_value(train_value),
    .flush(flush), .stat_correct(stat_correct), .stat_wrong(stat_wrong)
  );

  always #5 clk = ~clk;

  int chks = 0;
  int errs = 0;
  bit chk_on = 1'b0;

  // Model: per-entry contents and expected outputs (cur = now visible, nxt = after next edge)
  bit          m_valid [64];
  logic [7:0]  m_tag   [64];
  logic [31:0] m_val   [64];
  int          m_conf  [64];
  int          m_sc, m_sw;
  logic [31:0] cur_v, cur_h, cur_c, cur_val, cur_pc, cur_sc, cur_sw;
  logic [31:0] nxt_v, nxt_h, nxt_c, nxt_val, nxt_pc, nxt_sc, nxt_sw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = 0;
    end
    m_sc = 0; m_sw = 0;
    cur_v = 0; cur_h = 0; cur_c = 0; cur_val = 0; cur_pc = 0; cur_sc = 0; cur_sw = 0;
  endtask

  // Apply one cycle's rules to the model: response from pre-edge state, then training.
  task automatic model_step(input bit le, input logic [31:0] lpc, input bit te,
                            input logic [31:0] tpc, input logic [31:0] tv, input bit fl);
    int li, ti;
    bit hit;
    li = int'(lpc[7:2]);
    ti = int'(tpc[7:2]);
    if (le) begin
      hit     = m_valid[li] && (m_tag[li] == lpc[15:8]);
      nxt_v   = 1;
      nxt_h   = {31'd0, hit};
      nxt_c   = {31'd0, hit && (m_conf[li] >= 2)};
      nxt_val = hit ? m_val[li] : 32'd0;
      nxt_pc  = lpc;
    end else begin
      nxt_v = 0; nxt_h = cur_h; nxt_c = cur_c; nxt_val = cur_val; nxt_pc = cur_pc;
    end
    if (fl) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    end else if (te) begin
      hit = m_valid[ti] && (m_tag[ti] == tpc[15:8]);
      if (hit && m_val[ti] == tv) begin
        if (m_conf[ti] >= 2 && m_sc < 65535) m_sc++;
        if (m_conf[ti] < 3) m_conf[ti]++;
      end else if (hit) begin
        if (m_conf[ti] >= 2 && m_sw < 65535) m_sw++;
        m_val[ti] = tv; m_conf[ti] = 0;
      end else begin
        m_valid[ti] = 1'b1; m_tag[ti] = tpc[15:8]; m_val[ti] = tv; m_conf[ti] = 0;
      end
    end
    nxt_sc = m_sc;
    nxt_sw = m_sw;
  endtask

  // Drive one cycle (called just after a rising edge); returns #1 after the next edge.
  task automatic cyc(input bit le, input logic [31:0] lpc, input bit te,
                     input logic [31:0] tpc, input logic [31:0] tv, input bit fl);
    lookup_en = le; lookup_pc = lpc; train_en = te; train_pc = tpc; train_value = tv; flush = fl;
    model_step(le, lpc, te, tpc, tv, fl);
    @(posedge clk);
    cur_v = nxt_v; cur_h = nxt_h; cur_c = nxt_c; cur_val = nxt_val; cur_pc = nxt_pc;
    cur_sc = nxt_sc; cur_sw = nxt_sw;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] v);
    cyc(1'b0, 32'd0, 1'b1, pc, v, 1'b0);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pred_valid", {31'd0, pred_valid}, cur_v);
      chk("pred_hit", {31'd0, pred_hit}, cur_h);
      chk("pred_confident", {31'd0, pred_confident}, cur_c);
      chk("pred_value", pred_value, cur_val);
      chk("pred_pc", pred_pc, cur_pc);
      chk("stat_correct", {16'd0, stat_correct}, cur_sc);
      chk("stat_wrong", {16'd0, stat_wrong}, cur_sw);
    end
  end

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0110;
  localparam logic [31:0] PC = 32'h0040_0020;

  initial begin
    logic [31:0] vals [3];
    logic [31:0] rpc;
    rst_n = 1'b0; lookup_en = 1'b0; train_en = 1'b0; flush = 1'b0;
    lookup_pc = 32'd0; train_pc = 32'd0; train_value = 32'd0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_valid", {31'd0, pred_valid}, 32'd0);
    chk("reset_stats", {stat_correct, stat_wrong}, 32'd0);
    chk_on = 1'b1;

    look(PA);
    chk("cold_valid", {31'd0, pred_valid}, 32'd1);
    chk("cold_hit", {31'd0, pred_hit}, 32'd0);
    chk("cold_value", pred_value, 32'd0);

    repeat (3) train(PA, 32'hDEAD_BEEF);
    look(PA);
    chk("warm_hit", {31'd0, pred_hit}, 32'd1);
    chk("warm_conf", {31'd0, pred_confident}, 32'd1);
    chk("warm_value", pred_value, 32'hDEAD_BEEF);
    chk("warm_stats", {stat_correct, stat_wrong}, 32'd0);

    train(PA, 32'hDEAD_BEEF);
    chk("correct_1", {16'd0, stat_correct}, 32'd1);
    train(PA, 32'h1234_5678);
    chk("wrong_1", {16'd0, stat_wrong}, 32'd1);
    look(PA);
    chk("retrain_value", pred_value, 32'h1234_5678);
    chk("retrain_conf", {31'd0, pred_confident}, 32'd0);

    train(PB, 32'h5555_0000);
    look(PA);
    chk("alias_hit", {31'd0, pred_hit}, 32'd0);

    train(PA, 32'hAAAA_0001);
    cyc(1'b1, PA, 1'b1, PA, 32'hBBBB_0002, 1'b0);
    chk("rbw_old", pred_value, 32'hAAAA_0001);
    look(PA);
    chk("rbw_new", pred_value, 32'hBBBB_0002);

    cyc(1'b1, PA, 1'b1, PC, 32'h7777_7777, 1'b1);
    chk("flush_prestate", {31'd0, pred_hit}, 32'd1);
    look(PA);
    chk("flush_miss_a", {31'd0, pred_hit}, 32'd0);
    look(PC);
    chk("flush_miss_c", {31'd0, pred_hit}, 32'd0);

    vals[0] = 32'h0000_0001; vals[1] = 32'hCAFE_F00D; vals[2] = 32'h8000_0000;
    for (int n = 0; n < 3000; n++) begin
      bit le, te, fl;
      logic [31:0] tpc;
      le = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 99) == 0);
      te = !fl && ($urandom_range(0, 2) != 0);
      rpc = {16'h0040, 6'd0, 2'($urandom_range(0, 1)), 3'd0, 3'($urandom_range(0, 7)), 2'b00};
      tpc = {16'h0040, 6'd0, 2'($urandom_range(0, 1)), 3'd0, 3'($urandom_range(0, 7)), 2'b00};
      cyc(le, rpc, te, tpc, vals[$urandom_range(0, 2)], fl);
    end

    // Reset while a lookup response is pending: the response must be dropped.
    look(PA);
    chk_on = 1'b0;
    lookup_en = 1'b1; lookup_pc = PA;
    #2 rst_n = 1'b0;
    #1 chk("rst_drop_now", {31'd0, pred_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rst_drop_edge", {31'd0, pred_valid}, 32'd0);
    lookup_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    chk_on = 1'b1;
    chk("rst_stats", {stat_correct, stat_wrong}, 32'd0);

    for (int n = 0; n < 70003; n++) train(PA, 32'h0BAD_CAFE);
    chk("stat_sat", {16'd0, stat_correct}, 32'h0000_FFFF);
    look(PA);
    chk("sat_conf", {31'd0, pred_confident}, 32'd1);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule
